// File: rtl/chan_bitstream_reader_if.sv
// rtl/chan_bitstream_reader_if.sv - shared configuration flash access bus
// Purpose: groups the arbiter handshake (req/gnt) and the SPI pins of the
//          configuration flash into one bundle.
// Signals:
//   flash_req    reader -> arbiter  access request
//   flash_gnt    arbiter -> reader  access grant
//   flash_cs_n   reader -> flash    chip select, active low
//   flash_clk_en reader -> flash    SCK gate enable (SCK = ~clk when enabled)
//   flash_mosi   reader -> flash    command/address, MSB first
//   flash_miso   flash -> reader    read data
interface chan_bitstream_reader_if;
  logic flash_req;
  logic flash_gnt;
  logic flash_cs_n;
  logic flash_clk_en;
  logic flash_mosi;
  logic flash_miso;

  modport master (
    output flash_req,
    output flash_cs_n,
    output flash_clk_en,
    output flash_mosi,
    input  flash_gnt,
    input  flash_miso
  );

  modport slave (
    input  flash_req,
    input  flash_cs_n,
    input  flash_clk_en,
    input  flash_mosi,
    output flash_gnt,
    output flash_miso
  );
endinterface

// File: rtl/chan_bitstream_reader.sv
// rtl/chan_bitstream_reader.sv - SPI flash read engine for the channel bitstream
// Purpose: arbitrates for the configuration flash, sends a READ command with
//          a 24-bit address and streams BIT_COUNT data bits to the channel
//          programming sequencer, one bit per clk.
// Ports:
//   clk                    system clock
//   reset                  synchronous, active high
//   prog_chan_in_progress  session active; dropping it aborts a read
//   store_flash_command    strobe: reload the command shift register
//   read_bitstream         level: start/continue the read
//   bitstream              registered serial data (1 outside the data phase)
//   end_bitstream          high while the last data bit is on bitstream
//   flash                  flash bus (req/gnt + SPI pins), master side
module chan_bitstream_reader #(
  parameter logic [23:0] START_ADDR = 24'hCE0000,
  parameter logic [7:0]  READ_CMD   = 8'h03,
  parameter logic [31:0] BIT_COUNT  = 32'd9730592
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          prog_chan_in_progress,
  input  logic                          store_flash_command,
  input  logic                          read_bitstream,
  output logic                          bitstream,
  output logic                          end_bitstream,
  chan_bitstream_reader_if.master       flash
);

  localparam logic [31:0] CMD_WORD = {READ_CMD, START_ADDR};
  localparam logic [31:0] LAST_BIT = BIT_COUNT - 32'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_WAIT_GNT,
    ST_CMD,
    ST_DATA,
    ST_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cmd_sr_q, cmd_sr_d;
  logic [31:0] cnt_q, cnt_d;
  logic        bitstream_q, bitstream_d;
  logic        end_bitstream_q, end_bitstream_d;
  logic        flash_req_q, flash_req_d;
  logic        flash_cs_n_q, flash_cs_n_d;
  logic        flash_clk_en_q, flash_clk_en_d;
  logic        flash_mosi_q, flash_mosi_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      cmd_sr_q        <= CMD_WORD;
      cnt_q           <= 32'd0;
      bitstream_q     <= 1'b1;
      end_bitstream_q <= 1'b0;
      flash_req_q     <= 1'b0;
      flash_cs_n_q    <= 1'b1;
      flash_clk_en_q  <= 1'b0;
      flash_mosi_q    <= 1'b1;
    end else begin
      state_q         <= state_d;
      cmd_sr_q        <= cmd_sr_d;
      cnt_q           <= cnt_d;
      bitstream_q     <= bitstream_d;
      end_bitstream_q <= end_bitstream_d;
      flash_req_q     <= flash_req_d;
      flash_cs_n_q    <= flash_cs_n_d;
      flash_clk_en_q  <= flash_clk_en_d;
      flash_mosi_q    <= flash_mosi_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cmd_sr_d        = cmd_sr_q;
    cnt_d           = cnt_q;
    bitstream_d     = 1'b1;
    end_bitstream_d = 1'b0;
    flash_cs_n_d    = flash_cs_n_q;
    flash_clk_en_d  = flash_clk_en_q;
    flash_mosi_d    = flash_mosi_q;

    case (state_q)
      ST_IDLE: begin
        if (store_flash_command) begin
          cmd_sr_d = CMD_WORD;
          state_d  = ST_ARMED;
        end else if (read_bitstream) begin
          state_d = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (read_bitstream) begin
          state_d = ST_WAIT_GNT;
        end
      end

      ST_WAIT_GNT: begin
        if (flash.flash_gnt) begin
          state_d        = ST_CMD;
          cnt_d          = 32'd0;
          flash_cs_n_d   = 1'b0;
          flash_clk_en_d = 1'b1;
          flash_mosi_d   = cmd_sr_q[31];
        end
      end

      ST_CMD: begin
        // Rotate rather than shift: after the 32 command cycles the register
        // holds the stored command again, so a later read without a fresh
        // store resends the same command.
        cmd_sr_d = {cmd_sr_q[30:0], cmd_sr_q[31]};
        if (cnt_q == 32'd31) begin
          state_d      = ST_DATA;
          cnt_d        = 32'd0;
          flash_mosi_d = 1'b1;
        end else begin
          cnt_d        = cnt_q + 32'd1;
          flash_mosi_d = cmd_sr_q[30];
        end
      end

      ST_DATA: begin
        if (end_bitstream_q) begin
          // Last bit already delivered: release the flash one edge later.
          state_d        = ST_HOLD;
          flash_cs_n_d   = 1'b1;
          flash_clk_en_d = 1'b0;
        end else begin
          bitstream_d = flash.flash_miso;
          cnt_d       = cnt_q + 32'd1;
          if (cnt_q == LAST_BIT) begin
            end_bitstream_d = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        // A held read_bitstream must not start another read.
        if (store_flash_command) begin
          cmd_sr_d = CMD_WORD;
          state_d  = ST_ARMED;
        end else if (!read_bitstream) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!prog_chan_in_progress &&
        (state_q == ST_WAIT_GNT || state_q == ST_CMD || state_q == ST_DATA)) begin
      state_d         = ST_IDLE;
      bitstream_d     = 1'b1;
      end_bitstream_d = 1'b0;
      flash_cs_n_d    = 1'b1;
      flash_clk_en_d  = 1'b0;
      flash_mosi_d    = 1'b1;
    end

    flash_req_d = prog_chan_in_progress && (state_d != ST_IDLE);
  end

  assign bitstream          = bitstream_q;
  assign end_bitstream      = end_bitstream_q;
  assign flash.flash_req    = flash_req_q;
  assign flash.flash_cs_n   = flash_cs_n_q;
  assign flash.flash_clk_en = flash_clk_en_q;
  assign flash.flash_mosi   = flash_mosi_q;

endmodule
